uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin scheduler sharing one UART transmit line among NREQ byte producers. Each requester presents a byte and raises a request; the block grants one requester at a time, latches its byte, and serialises it on Uart_TX with an internal bit-period counter driven by the system clock. It sits between the on-chip message sources and the board TX pin. It replaces per-source transmitters and free-running divided clocks with one timed, arbitrated transmitter.

## Interface
- NREQ, 4: number of requesters, 2..8
- CLKS_PER_BIT, 326: Sys_CLK cycles per serial bit, ≥2; counter width $clog2(CLKS_PER_BIT)
- Sys_CLK  input  1  system clock, all logic on rising edge
- Sys_RST  input  1  reset, asynchronous, active-high
- Req  input  NREQ  per-requester transmit request, level
- Data  input  8*NREQ  byte of requester i at Data[8i+7:8i]
- Grant  output  NREQ  one-hot, one-cycle pulse: requester's byte accepted
- Busy  output  1  high while a frame is on the line
- Done  output  1  one-cycle pulse at end of each stop bit
- Uart_TX  output  1  serial line, idle high

## Operation
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- Arbitration at any edge where state is IDLE, or where STOP is ending, and |Req=1: winner = first i with Req[i]=1 searching from ptr+1 upward mod NREQ; ptr <= winner; shift register <= Data of winner; state -> START.
- Frame: start bit 0, Data[0]..Data[7] LSB first, optional parity, stop bit 1.
- Bit counter counts 0..CLKS_PER_BIT-1 per bit; state advances on terminal count. DATA uses a 3-bit index; leaves DATA after bit 7.
- STOP terminal count: Done=1 next cycle; if |Req, re-arbitrate (back-to-back, no idle gap); else -> IDLE.
- Data is sampled only at grant; later changes to Data do not affect the frame.
- Req held high after Grant counts as a fresh request; a requester wanting one frame drops Req in the cycle Grant is seen. Req dropped before grant is a withdrawal; no grant is issued.
- Req and Data of non-winners are ignored; no queueing beyond the Req level.

## Timing
- Reset values (asynchronous): Uart_TX=1, Grant=0, Busy=0, Done=0, state IDLE, ptr=NREQ-1 (requester 0 wins first), counters 0.
- Grant latency: Req sampled high at edge T in IDLE -> Grant, Busy, Uart_TX=0 all registered high/low in cycle T+1 (Grant for exactly one cycle).
- Each bit is exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles (11* with parity), from first cycle of start bit to last cycle of stop bit.
- Done asserted in the cycle after the last stop-bit cycle; in back-to-back case the same cycle carries Grant and start bit (Busy stays 1).
- Busy falls in the cycle Done is high when no request is pending.
- Simultaneous requests: at most one Grant bit per arbitration; ptr rotation guarantees each persistent requester a grant within NREQ frames.
- Reset mid-frame aborts immediately: line returns high, partial frame lost, no Done.

## Configuration
- UART_PARITY_EN defined: PARITY state inserted after DATA, drives even parity (XOR of the 8 latched bits) for one bit period; frame 11 bits.
- Undefined: no PARITY state, STOP follows bit 7; frame 10 bits.

## Test plan
- Reset: assert Sys_RST mid-frame -> Uart_TX=1, Busy=0, Grant=0 within same cycle; after release, idle line stays 1.
- Single byte, CLKS_PER_BIT=4, Req[0] with Data=0xA5 -> Grant=0001 one cycle, Uart_TX pattern 0,1,0,1,0,0,1,0,1,1 each 4 cycles, Done after 40 cycles.
- All four Req held high, bytes 0x11/0x22/0x33/0x44 -> grants 0,1,2,3,0 in order, back-to-back frames, no idle cycles between stop and start.
- Req[2] raised then dropped before Busy clears -> no Grant[2]; line idle after current frame.
- Data changed mid-frame from 0x0F to 0xF0 -> transmitted byte remains 0x0F.
- UART_PARITY_EN, Data=0x07 -> parity bit 1, frame 44 cycles; Data=0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if
//   Bundle of the request/grant and serial-line signals between the
//   message sources and the shared UART transmitter.
//   Req     : per-requester transmit request (level)
//   Data    : byte of requester i at Data[8i+7:8i]
//   Grant   : one-hot, one-cycle pulse when a requester's byte is accepted
//   Busy    : high while a frame is on the line
//   Done    : one-cycle pulse after each stop bit
//   Uart_TX : serial line, idle high
//   Modports: master = requester side, slave = transmitter side.
interface uart_tx_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   Req;
    logic [8*NREQ-1:0] Data;
    logic [NREQ-1:0]   Grant;
    logic              Busy;
    logic              Done;
    logic              Uart_TX;

    modport master (
        output Req, Data,
        input  Grant, Busy, Done, Uart_TX
    );

    modport slave (
        input  Req, Data,
        output Grant, Busy, Done, Uart_TX
    );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Round-robin arbiter in front of a single UART transmitter. One requester
//   is granted per frame, its byte is latched at grant, and the frame
//   (start, 8 data bits LSB first, optional even parity, stop) is timed by an
//   internal bit-period counter on Sys_CLK.
//   Ports:
//     Sys_CLK : system clock, rising edge
//     Sys_RST : asynchronous active-high reset
//     bus     : uart_tx_sched_if.slave (Req, Data in; Grant, Busy, Done, Uart_TX out)
//   Build option:
//     UART_PARITY_EN : insert an even-parity bit after the data bits
module uart_tx_sched #(
    parameter int NREQ         = 4,
    parameter int CLKS_PER_BIT = 326
) (
    input  logic          Sys_CLK,
    input  logic          Sys_RST,
    uart_tx_sched_if.slave bus
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [NREQ-1:0] grant_q, grant_d;
`ifdef UART_PARITY_EN
    logic            par_q, par_d;
`endif

    logic            cnt_end;
    logic            any_req;
    logic [PW-1:0]   win;
    logic [7:0]      win_byte;

    assign cnt_end = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign any_req = |bus.Req;

    // Round-robin search starting just after the last winner. The loop runs
    // from the farthest candidate to the nearest so the nearest hit is the
    // last assignment and therefore wins.
    always_comb begin
        int idx;
        win = ptr_q;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (bus.Req[idx]) win = PW'(idx);
        end
    end

    assign win_byte = bus.Data[int'(win)*8 +: 8];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        grant_d = '0;
`ifdef UART_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                cnt_d  = '0;
            end
            START: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_end) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                    tx_d    = sh_q[0];
                    sh_d    = {1'b0, sh_q[7:1]};
                end
            end
            DATA: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = sh_q[0];
                        sh_d  = {1'b0, sh_q[7:1]};
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_end) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_end) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase

        // Arbitration overrides the idle/stop exit above, which is what makes
        // back-to-back frames start with no idle cycle.
        if (any_req && ((state_q == IDLE) || (state_q == STOP && cnt_end))) begin
            state_d = START;
            ptr_d   = win;
            sh_d    = win_byte;
            grant_d = NREQ'(1) << win;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
            cnt_d   = '0;
`ifdef UART_PARITY_EN
            par_d   = ^win_byte;
`endif
        end
    end

    always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
        if (Sys_RST) begin
            state_q <= IDLE;
            ptr_q   <= PW'(NREQ - 1);
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            grant_q <= '0;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            grant_q <= grant_d;
`ifdef UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.Grant   = grant_q;
    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
    assign bus.Uart_TX = tx_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;
    localparam int NREQ = 4;
    localparam int C    = 4;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    uart_tx_sched_if #(.NREQ(NREQ)) bus ();

    uart_tx_sched #(.NREQ(NREQ), .CLKS_PER_BIT(C)) dut (
        .Sys_CLK (clk),
        .Sys_RST (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]   req;
        logic [8*NREQ-1:0] data;
        int                exp_w;
        logic [7:0]        exp_b;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line level expected during frame bit k for byte b.
    function automatic logic fbit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Round-robin reference: first requester after the last winner.
    function automatic int arb(input logic [NREQ-1:0] r, input int ptr);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Entered #1 after the grant edge. Checks the grant pulse and every cycle
    // of the frame; returns positioned in the last stop-bit cycle.
    task automatic xmit_check(input int w, input logic [7:0] b,
                              input logic [NREQ-1:0] nreq,
                              input logic [8*NREQ-1:0] ndata, input int wd);
        chk("grant", 32'(bus.Grant), 32'(1) << w);
        chk("busy_start", 32'(bus.Busy), 1);
        bus.Req  = nreq;
        bus.Data = ndata;
        for (int c = 0; c < NB*C; c++) begin
            if (c > 0) begin
                step();
                chk("grant_pulse", 32'(bus.Grant), 0);
                chk("done_mid", 32'(bus.Done), 0);
                chk("busy_mid", 32'(bus.Busy), 1);
            end
            chk("tx", 32'(bus.Uart_TX), 32'(fbit(b, c / C)));
            if (c == wd) bus.Req = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.Req  = '0;
        bus.Data = '0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        int                rr[5];
        int                ptr_m, w;
        logic [NREQ-1:0]   req, nreq;
        logic [8*NREQ-1:0] data, ndata;
        logic [7:0]        b;

        tbl[0] = '{4'b0001, 32'h0000_00A5, 0, 8'hA5};
        tbl[1] = '{4'b0110, 32'h00C3_5A00, 1, 8'h5A};
        tbl[2] = '{4'b0011, 32'h0000_000F, 0, 8'h0F};
        tbl[3] = '{4'b1100, 32'h0081_0000, 2, 8'h81};
        tbl[4] = '{4'b1101, 32'hFF00_0000, 3, 8'hFF};
        tbl[5] = '{4'b1111, 32'h0000_0000, 0, 8'h00};
        tbl[6] = '{4'b0001, 32'h0000_0007, 0, 8'h07};
        tbl[7] = '{4'b0001, 32'h0000_0003, 0, 8'h03};
        rr = '{0, 1, 2, 3, 0};

        bus.Req  = '0;
        bus.Data = '0;
        step();
        chk("rst_tx", 32'(bus.Uart_TX), 1);
        chk("rst_busy", 32'(bus.Busy), 0);
        chk("rst_grant", 32'(bus.Grant), 0);
        chk("rst_done", 32'(bus.Done), 0);
        do_reset();

        // Table: ptr sequence from reset makes the expected winners fixed.
        for (int i = 0; i < 8; i++) begin
            bus.Req  = tbl[i].req;
            bus.Data = tbl[i].data;
            step();
            xmit_check(tbl[i].exp_w, tbl[i].exp_b, '0, ~tbl[i].data, -1);
            step();
            chk("done", 32'(bus.Done), 1);
            chk("busy_end", 32'(bus.Busy), 0);
            chk("grant_end", 32'(bus.Grant), 0);
            chk("tx_idle", 32'(bus.Uart_TX), 1);
            step();
            chk("done_pulse", 32'(bus.Done), 0);
        end

        // Reset mid-frame aborts at once.
        bus.Req  = 4'b0001;
        bus.Data = 32'h0000_0000;
        step();
        bus.Req = '0;
        repeat (15) step();
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", 32'(bus.Uart_TX), 1);
        chk("mid_rst_busy", 32'(bus.Busy), 0);
        chk("mid_rst_grant", 32'(bus.Grant), 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("post_rst_tx", 32'(bus.Uart_TX), 1);
            chk("post_rst_done", 32'(bus.Done), 0);
        end

        // All four held: 0,1,2,3,0 back-to-back.
        do_reset();
        bus.Req  = 4'b1111;
        bus.Data = 32'h4433_2211;
        step();
        for (int f = 0; f < 5; f++) begin
            xmit_check(rr[f], 8'((rr[f] + 1) * 17), (f < 4) ? 4'b1111 : 4'b0000,
                       32'h4433_2211, -1);
            step();
            chk("rr_done", 32'(bus.Done), 1);
            chk("rr_busy", 32'(bus.Busy), (f < 4) ? 1 : 0);
        end

        // Req[2] raised mid-frame then withdrawn: no grant, line idles.
        step();
        bus.Req  = 4'b0001;
        bus.Data = 32'h0000_005A;
        step();
        xmit_check(0, 8'h5A, 4'b0100, 32'h0000_005A, 5*C);
        step();
        chk("wd_done", 32'(bus.Done), 1);
        chk("wd_busy", 32'(bus.Busy), 0);
        chk("wd_grant", 32'(bus.Grant), 0);
        for (int i = 0; i < 3*C; i++) begin
            step();
            chk("wd_idle_grant", 32'(bus.Grant), 0);
            chk("wd_idle_tx", 32'(bus.Uart_TX), 1);
        end

        // Random requests against the round-robin reference.
        do_reset();
        ptr_m = NREQ - 1;
        req   = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        data  = $urandom;
        bus.Req  = req;
        bus.Data = data;
        step();
        for (int f = 0; f < 25; f++) begin
            w     = arb(req, ptr_m);
            ptr_m = w;
            b     = data[w*8 +: 8];
            nreq  = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom_range(1, (1 << NREQ) - 1));
            ndata = $urandom;
            xmit_check(w, b, nreq, ndata, -1);
            step();
            chk("rnd_done", 32'(bus.Done), 1);
            if (nreq != '0) begin
                req  = nreq;
                data = ndata;
            end else begin
                chk("rnd_busy", 32'(bus.Busy), 0);
                chk("rnd_grant", 32'(bus.Grant), 0);
                repeat ($urandom_range(0, 3)) step();
                req  = NREQ'($urandom_range(1, (1 << NREQ) - 1));
                data = $urandom;
                bus.Req  = req;
                bus.Data = data;
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
